// File: rtl/sample_stream_fifo.sv
// sample_stream_fifo: single-clock valid/ready stream FIFO with level output.
// The producer sees stream_in_ready and the consumer sees stream_out_valid.
// Both are decoded from registered state and flush only, so there is no path
// from stream_out_ready to stream_in_ready.
// Optional statistics counters are enabled by defining SAMPLE_STREAM_STATS_EN.
module sample_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         stream_in_valid,
  output logic                         stream_in_ready,
  input  logic [DATA_WIDTH-1:0]        stream_in_data,
  output logic                         stream_out_valid,
  input  logic                         stream_out_ready,
  output logic [DATA_WIDTH-1:0]        stream_out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef SAMPLE_STREAM_STATS_EN
  ,
  output logic [15:0]                  push_count,
  output logic [15:0]                  pop_count,
  output logic [15:0]                  stall_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  run_q, run_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push, pop;

  // Handshake decode; run_q keeps ready low until the first edge after reset.
  always_comb begin
    stream_in_ready  = run_q && (level_q < LVL_W'(DEPTH)) && !flush;
    stream_out_valid = (level_q != '0) && !flush;
    stream_out_data  = mem_q[rd_ptr_q];
    level            = level_q;
    push             = stream_in_valid && stream_in_ready;
    pop              = stream_out_valid && stream_out_ready;
  end

  // Pointer, level and run-flag next state; flush returns to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    run_d    = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      run_q    <= run_d;
    end
  end

  // Storage write; contents are never cleared.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = stream_in_data;
  end

  // Storage array, no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SAMPLE_STREAM_STATS_EN
  logic [15:0] push_cnt_q, push_cnt_d;
  logic [15:0] pop_cnt_q, pop_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Statistics next state: wrapping handshake counts, saturating stall count.
  always_comb begin
    push_cnt_d  = push_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push) push_cnt_d = push_cnt_q + 16'd1;
    if (pop)  pop_cnt_d  = pop_cnt_q + 16'd1;
    if (stream_in_valid && !stream_in_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Statistics registers; cleared by reset only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign push_count  = push_cnt_q;
  assign pop_count   = pop_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
